// File: rtl/legv8_multicycle_ctrl.sv
// Main control FSM for the multicycle LEGv8 datapath: sequences fetch/decode/
// execute/memory/writeback, drives mux selects and strobes, counts retirements.
module legv8_multicycle_ctrl #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [10:0]        opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [1:0]         ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               Reg2Loc,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCSrc,
  output logic               RegWrite,
  output logic               MemtoReg,
  output logic               FlagWrite,
  output logic               instr_done,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] EXEC_R   = 4'd2;
  localparam logic [3:0] EXEC_I   = 4'd3;
  localparam logic [3:0] WB_ALU   = 4'd4;
  localparam logic [3:0] MEM_ADDR = 4'd5;
  localparam logic [3:0] MEM_RD   = 4'd6;
  localparam logic [3:0] MEM_WB   = 4'd7;
  localparam logic [3:0] MEM_WR   = 4'd8;
  localparam logic [3:0] BR_CBZ   = 4'd9;
  localparam logic [3:0] BR_B     = 4'd10;
  localparam logic [3:0] HALT     = 4'd11;

  logic [3:0] state, nxt;
  logic is_rtype, is_addi, is_ldur, is_stur, is_cbz, is_b;

  assign is_rtype = (opcode == 11'b10101011000) || (opcode == 11'b11101011000);
  assign is_addi  = (opcode[10:1] == 10'b1001000100);
  assign is_ldur  = (opcode == 11'b11111000010);
  assign is_stur  = (opcode == 11'b11111000000);
  assign is_cbz   = (opcode[10:3] == 8'b10110100);
  assign is_b     = (opcode[10:5] == 6'b000101);

  always_comb begin
    nxt        = state;
    ALUOp      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    Reg2Loc    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    FlagWrite  = 1'b0;
    instr_done = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          nxt     = DECODE;
        end
      end
      DECODE: begin
        // ALU precomputes the branch target while the register file reads
        ALUSrcB = 2'b11;
        Reg2Loc = is_stur || is_cbz;
        if (is_rtype)                nxt = EXEC_R;
        else if (is_addi)            nxt = EXEC_I;
        else if (is_ldur || is_stur) nxt = MEM_ADDR;
        else if (is_cbz)             nxt = BR_CBZ;
        else if (is_b)               nxt = BR_B;
        else                         nxt = HALT;
      end
      EXEC_R: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b10;
        FlagWrite = 1'b1;
        nxt       = WB_ALU;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b10;
        nxt     = WB_ALU;
      end
      WB_ALU: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        Reg2Loc = is_stur;
        nxt     = is_ldur ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) nxt = MEM_WB;
      end
      MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Reg2Loc  = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          nxt        = FETCH;
        end
      end
      BR_CBZ: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        Reg2Loc    = 1'b1;
        PCSrc      = 1'b1;
        PCWrite    = zero;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      BR_B: begin
        PCSrc      = 1'b1;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      HALT:    nxt = HALT;
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= nxt;
      if (nxt == HALT) illegal <= 1'b1;
      if (instr_done)  instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed bench for legv8_multicycle_ctrl; a second 3-bit-counter instance
// exercises counter wrap without needing 2^32 retirements.
module tb_legv8_multicycle_ctrl;

  logic clk = 1'b0, reset_n = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic [10:0] opcode = 11'b10101011000;

  logic [1:0] ALUOp, ALUSrcB, s_ALUOp, s_ALUSrcB;
  logic ALUSrcA, Reg2Loc, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc;
  logic RegWrite, MemtoReg, FlagWrite, instr_done, illegal;
  logic s_ALUSrcA, s_Reg2Loc, s_IorD, s_MemRead, s_MemWrite, s_IRWrite, s_PCWrite, s_PCSrc;
  logic s_RegWrite, s_MemtoReg, s_FlagWrite, s_instr_done, s_illegal;
  logic [31:0] instr_count;
  logic [2:0]  s_instr_count;
  logic [16:0] ctrl, s_ctrl;
  int errs = 0, nchk = 0;

  localparam logic [10:0] OP_ADDS = 11'b10101011000, OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_ADDI = 11'b10010001001, OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000, OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010100000, OP_BAD  = 11'b00000000000;

  always #5 clk = ~clk;

  legv8_multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .Reg2Loc(Reg2Loc), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .FlagWrite(FlagWrite),
    .instr_done(instr_done), .illegal(illegal), .instr_count(instr_count)
  );

  legv8_multicycle_ctrl #(.COUNT_W(3)) dut_w (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALUOp(s_ALUOp), .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB), .Reg2Loc(s_Reg2Loc),
    .IorD(s_IorD), .MemRead(s_MemRead), .MemWrite(s_MemWrite), .IRWrite(s_IRWrite),
    .PCWrite(s_PCWrite), .PCSrc(s_PCSrc), .RegWrite(s_RegWrite), .MemtoReg(s_MemtoReg),
    .FlagWrite(s_FlagWrite), .instr_done(s_instr_done), .illegal(s_illegal),
    .instr_count(s_instr_count)
  );

  assign ctrl = {ALUOp, ALUSrcA, ALUSrcB, Reg2Loc, IorD, MemRead, MemWrite, IRWrite,
                 PCWrite, PCSrc, RegWrite, MemtoReg, FlagWrite, instr_done};
  assign s_ctrl = {s_ALUOp, s_ALUSrcA, s_ALUSrcB, s_Reg2Loc, s_IorD, s_MemRead, s_MemWrite,
                   s_IRWrite, s_PCWrite, s_PCSrc, s_RegWrite, s_MemtoReg, s_FlagWrite,
                   s_instr_done};

  function automatic logic [16:0] mk(input logic [1:0] aop, input logic sa, input logic [1:0] sb,
      input logic r2l, iord, mr, mw, irw, pcw, pcs, rw, m2r, fw, done);
    return {aop, sa, sb, r2l, iord, mr, mw, irw, pcw, pcs, rw, m2r, fw, done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // check both instances' strobes mid-cycle, then advance to the next negedge
  task automatic cyc(input string tag, input logic [16:0] exp);
    #1;
    chk(tag, {15'd0, ctrl}, {15'd0, exp});
    chk({tag, "_w"}, {15'd0, s_ctrl}, {15'd0, exp});
    @(negedge clk);
  endtask

  logic [16:0] E_FETCH, E_FWAIT, E_DEC, E_DEC_R2L, E_EXR, E_EXI, E_WB, E_MA, E_MA_STUR;
  logic [16:0] E_MRD, E_MWB, E_MWR, E_MWR_DONE, E_CBZ_T, E_CBZ_N, E_BRB, E_NONE;

  task automatic run_b(input string tag);
    opcode = OP_B;
    cyc({tag, "_f"}, E_FETCH);
    cyc({tag, "_d"}, E_DEC);
    cyc({tag, "_br"}, E_BRB);
  endtask

  initial begin
    //                aop  sa sb    r2l io mr mw ir pw ps rw m2 fw dn
    E_FETCH    = mk(2'b00,0,2'b01, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    E_FWAIT    = mk(2'b00,0,2'b01, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    E_DEC      = mk(2'b00,0,2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    E_DEC_R2L  = mk(2'b00,0,2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    E_EXR      = mk(2'b10,1,2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    E_EXI      = mk(2'b10,1,2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    E_WB       = mk(2'b00,0,2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    E_MA       = mk(2'b00,1,2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    E_MA_STUR  = mk(2'b00,1,2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    E_MRD      = mk(2'b00,0,2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    E_MWB      = mk(2'b00,0,2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    E_MWR      = mk(2'b00,0,2'b00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    E_MWR_DONE = mk(2'b00,0,2'b00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    E_CBZ_T    = mk(2'b01,1,2'b00, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    E_CBZ_N    = mk(2'b01,1,2'b00, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    E_BRB      = mk(2'b00,0,2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    E_NONE     = '0;

    // reset: FETCH outputs with mem_ready=0 (no IRWrite/PCWrite)
    mem_ready = 1'b0;
    #3;
    chk("rst_ctrl", {15'd0, ctrl}, {15'd0, E_FWAIT});
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_count", instr_count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // FETCH holds while memory stalls, then ADDS
    opcode = OP_ADDS;
    cyc("adds_fwait", E_FWAIT);
    mem_ready = 1'b1;
    cyc("adds_f", E_FETCH);
    cyc("adds_d", E_DEC);
    cyc("adds_ex", E_EXR);
    cyc("adds_wb", E_WB);
    #1 chk("adds_count", instr_count, 32'd1);

    // LDUR with two wait cycles in MEM_RD; mem_ready ignored in DECODE/MEM_ADDR
    opcode = OP_LDUR;
    cyc("ldur_f", E_FETCH);
    mem_ready = 1'b0;
    cyc("ldur_d", E_DEC);
    cyc("ldur_ma", E_MA);
    cyc("ldur_rd0", E_MRD);
    cyc("ldur_rd1", E_MRD);
    mem_ready = 1'b1;
    cyc("ldur_rd2", E_MRD);
    cyc("ldur_wb", E_MWB);
    #1 chk("ldur_count", instr_count, 32'd2);

    // CBZ taken, then not taken
    opcode = OP_CBZ;
    zero = 1'b1;
    cyc("cbzt_f", E_FETCH);
    cyc("cbzt_d", E_DEC_R2L);
    cyc("cbzt_br", E_CBZ_T);
    zero = 1'b0;
    cyc("cbzn_f", E_FETCH);
    cyc("cbzn_d", E_DEC_R2L);
    cyc("cbzn_br", E_CBZ_N);
    #1 chk("cbz_count", instr_count, 32'd4);

    // STUR zero-wait: single MemWrite cycle
    opcode = OP_STUR;
    cyc("stur_f", E_FETCH);
    cyc("stur_d", E_DEC_R2L);
    cyc("stur_ma", E_MA_STUR);
    cyc("stur_wr", E_MWR_DONE);
    cyc("stur_next", E_FETCH);
    #1 chk("stur_count", instr_count, 32'd5);
    opcode = OP_B;
    cyc("b_d", E_DEC);
    cyc("b_br", E_BRB);

    // ADDI (low bit don't-care) and SUBS
    opcode = OP_ADDI;
    cyc("addi_f", E_FETCH);
    cyc("addi_d", E_DEC);
    cyc("addi_ex", E_EXI);
    cyc("addi_wb", E_WB);
    opcode = OP_SUBS;
    cyc("subs_f", E_FETCH);
    cyc("subs_d", E_DEC);
    cyc("subs_ex", E_EXR);
    cyc("subs_wb", E_WB);
    #1 chk("mix_count", instr_count, 32'd8);

    // illegal opcode -> HALT, sticky and silent even with strobing inputs
    opcode = OP_BAD;
    cyc("bad_f", E_FETCH);
    cyc("bad_d", E_DEC);
    for (int i = 0; i < 10; i++) begin
      zero = i[0];
      mem_ready = i[1];
      #1 chk("halt_illegal", {31'd0, illegal}, 32'd1);
      cyc("halt_ctrl", E_NONE);
    end
    #1 chk("halt_count", instr_count, 32'd8);
    mem_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("halt_rst_illegal", {31'd0, illegal}, 32'd0);
    chk("halt_rst_ctrl", {15'd0, ctrl}, {15'd0, E_FETCH});
    @(negedge clk);
    reset_n = 1'b1;

    // reset asserted mid-cycle while stalled in MEM_WR
    opcode = OP_STUR;
    cyc("rstwr_f", E_FETCH);
    cyc("rstwr_d", E_DEC_R2L);
    mem_ready = 1'b0;
    cyc("rstwr_ma", E_MA_STUR);
    #1 chk("rstwr_wr", {15'd0, ctrl}, {15'd0, E_MWR});
    #2 reset_n = 1'b0;
    #1;
    chk("rstwr_memwrite", {31'd0, MemWrite}, 32'd0);
    chk("rstwr_memread", {31'd0, MemRead}, 32'd1);
    chk("rstwr_count", instr_count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mem_ready = 1'b1;

    // counter wrap on the 3-bit instance: 7 retirements reach all-ones, 8th wraps
    for (int i = 0; i < 7; i++) run_b("wrap");
    #1 chk("wrap_ones", {29'd0, s_instr_count}, 32'd7);
    run_b("wrap_last");
    #1;
    chk("wrap_zero", {29'd0, s_instr_count}, 32'd0);
    chk("wrap_wide", instr_count, 32'd8);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/legv8_multicycle_ctrl.md
Name: legv8_multicycle_ctrl

Overview:
- Main control FSM for the multicycle LEGv8 datapath; sits directly upstream of the ALU control decoder and drives its 2-bit ALUOp.
- Steps each instruction through fetch/decode/execute/memory/writeback states from the 11-bit opcode held in IR.
- Generates datapath mux selects and write enables, and handshakes with a single shared memory port.
- Counts retired instructions.

Parameters:
- COUNT_W, 32, width of the retired-instruction counter (wraps modulo 2^COUNT_W).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  11  IR[31:21]; stable from the cycle after IRWrite
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- ALUOp  out  2  00 add, 01 pass-B/compare, 10 decode opcode field
- ALUSrcA  out  1  0 PC, 1 register Rn
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-extended immediate/address, 11 branch offset<<2
- Reg2Loc  out  1  1 selects Rt as read register 2
- IorD  out  1  memory address: 0 PC, 1 ALUOut
- MemRead  out  1  read strobe
- MemWrite  out  1  write strobe
- IRWrite  out  1  load IR
- PCWrite  out  1  load PC
- PCSrc  out  1  0 ALU result, 1 ALUOut (branch target)
- RegWrite  out  1  register file write
- MemtoReg  out  1  writeback source: 0 ALUOut, 1 MDR
- FlagWrite  out  1  update NZCV
- instr_done  out  1  one-cycle retire pulse
- illegal  out  1  sticky illegal-opcode flag
- instr_count  out  COUNT_W  retired instructions

Behaviour:
- Only the state register, illegal and instr_count are registered; all other outputs are combinational from state, opcode, mem_ready and zero.
- Any output not listed for a state is 0; ALUOp defaults to 00.
- Reset (async, any time, including mid-access): state=FETCH, illegal=0, instr_count=0.
  - All strobes and enables drop in the same instant reset asserts.
  - MemRead is 1 during reset because FETCH is the reset state.
- Opcode decode (from DECODE):
  - ADDS 10101011000 and SUBS 11101011000 -> EXEC_R
  - ADDI 1001000100x -> EXEC_I
  - LDUR 11111000010 and STUR 11111000000 -> MEM_ADDR
  - CBZ 10110100xxx -> BR_CBZ
  - B 000101xxxxx -> BR_B
  - Anything else -> HALT
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - mem_ready=0: hold.
  - mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=0; next DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut); Reg2Loc=1 for STUR or CBZ. Next state per decode table.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10, FlagWrite=1 -> WB_ALU.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=10 -> WB_ALU.
- WB_ALU: RegWrite=1, MemtoReg=0, instr_done=1 -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, Reg2Loc=1 for STUR; next MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD: MemRead=1, IorD=1; hold until mem_ready, then -> MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, instr_done=1 -> FETCH.
- MEM_WR: MemWrite=1, IorD=1, Reg2Loc=1; hold until mem_ready. On mem_ready: instr_done=1, -> FETCH.
- BR_CBZ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Reg2Loc=1, PCSrc=1, PCWrite=zero, instr_done=1 -> FETCH.
- BR_B: PCSrc=1, PCWrite=1, instr_done=1 -> FETCH.
- HALT: all outputs 0 except illegal=1 (set on entry, sticky); stays until reset.
- Latency with zero-wait memory, FETCH to retire inclusive:
  - ADDS/SUBS/ADDI 4, LDUR 5, STUR 4, CBZ 3, B 3.
  - Each wait cycle (mem_ready=0) adds one cycle.
- instr_count increments by 1 on every clk edge where instr_done=1; it wraps from all-ones to 0.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.

Test Plan:
- Reset, mem_ready=1, opcode=10101011000 (ADDS) -> states FETCH, DECODE, EXEC_R (ALUOp=10, FlagWrite=1), WB_ALU (RegWrite=1, instr_done=1); instr_count=1 after 4 cycles.
- LDUR 11111000010, mem_ready low for 2 cycles in MEM_RD -> MemRead=1 and IorD=1 held 3 cycles, then MEM_WB with MemtoReg=1; 7 cycles total; instr_count increments once.
- CBZ 10110100101: zero=1 -> PCWrite=1 and PCSrc=1 in the 3rd cycle; zero=0 -> PCWrite=0; instr_done=1 in both cases.
- STUR 11111000000 -> Reg2Loc=1 in DECODE, MEM_ADDR and MEM_WR; MemWrite=1 exactly one cycle with mem_ready=1; RegWrite never 1.
- Opcode 00000000000 -> HALT, illegal=1 sticky over 10 cycles with no strobes; assert reset_n=0 -> illegal=0, state=FETCH.
- reset_n pulled low mid MEM_WR (mem_ready=0) -> MemWrite drops with no clock edge; instr_count=0. Force instr_count to all-ones, retire one instruction -> count reads 0.
